// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick helper for mux_sel_arbiter.
// Included by the arbiter top and its pick sub-module.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE,
      OWN
   } arb_state_e;

   // Returns {found, idx}; idx is the first set bit searching ptr, ptr+1, ...
   function automatic logic [SEL_W:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [SEL_W-1:0] ptr
   );
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [SEL_W:0]     r;
      dbl = {req, req};
      rot = dbl[ptr +: N_REQ];
      r   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            r = {1'b1, SEL_W'(int'(ptr) + k)};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_pick.sv
// rr_pick_4: rotate / priority-encode / unrotate over masked requests.
// Mask removes the releasing owner during a direct handoff.
module rr_pick_4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   assign {found, idx} = rr_pick(req & ~mask, ptr);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter driving the shared 4:1 operand/write-back mux.
// Optional forced revoke after MAX_HOLD cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             timeout
);

   arb_state_e       state, state_d;
   logic [SEL_W-1:0] ptr, ptr_d;
   logic [N_REQ-1:0] grant_d;
   logic [SEL_W-1:0] sel_d;
   logic             busy_d;
   logic             own;
   logic             rel_norm;
   logic             force_rev;
   logic             rel;
   logic             new_grant;
   logic [N_REQ-1:0] mask;
   logic [SEL_W-1:0] pick_ptr;
   logic             found;
   logic [SEL_W-1:0] idx;

   assign own      = (state == OWN);
   assign rel_norm = own & (done[sel] | ~req[sel]);
   assign rel      = rel_norm | force_rev;
   assign pick_ptr = own ? SEL_W'(sel + 1'b1) : ptr;

   always_comb begin
      mask = '0;
      if (own) begin
         mask[sel] = 1'b1;
      end
   end

   rr_pick_4 u_pick (
      .req   (req),
      .mask  (mask),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: if (found) state_d = OWN;
         OWN:  if (rel && !found) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d   = grant;
      sel_d     = sel;
      busy_d    = busy;
      ptr_d     = ptr;
      new_grant = 1'b0;
      if (((state == IDLE) || rel) && found) begin
         grant_d      = '0;
         grant_d[idx] = 1'b1;
         sel_d        = idx;
         busy_d       = 1'b1;
         new_grant    = 1'b1;
      end else if (rel) begin
         grant_d = '0;
         busy_d  = 1'b0;
      end
      if (rel) begin
         ptr_d = SEL_W'(sel + 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
      end else begin
         grant <= grant_d;
         sel   <= sel_d;
         busy  <= busy_d;
         ptr   <= ptr_d;
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;

   // Revoke only when the owner has not already released this cycle.
   assign force_rev = own & ~rel_norm & (hold_cnt == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= force_rev;
         if (new_grant) begin
            hold_cnt <= '0;
         end else if (own) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end
`else
   assign force_rev = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a per-cycle ownership model.
// Define MUX_ARB_TIMEOUT_EN for both bench and RTL to exercise forced revoke.
module tb_mux_sel_arbiter;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   int n_chk  = 0;
   int n_fail = 0;

   int m_owner = -1;
   int m_sel   = 0;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_to    = 0;
   bit started = 0;

   always #5 clk = ~clk;

   mux_sel_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Ownership model: who owns the path, whose turn is next.
   always @(posedge clk) begin
      bit timed, normal;
      int nxt;
      started = 1;
      m_to = 0;
      if (!reset_n) begin
         m_owner = -1;
         m_sel   = 0;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               m_sel   = m_owner;
               m_hold  = 0;
            end
         end
      end else begin
         normal = done[m_owner] || !req[m_owner];
         timed  = 0;
`ifdef MUX_ARB_TIMEOUT_EN
         timed = !normal && (m_hold == MH - 1);
`endif
         if (normal || timed) begin
            m_to  = timed;
            m_ptr = (m_owner + 1) % 4;
            nxt   = -1;
            for (int k = 1; k < 4; k++) begin
               if (nxt < 0 && req[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
            end
            m_owner = nxt;
            if (nxt >= 0) begin
               m_sel  = nxt;
               m_hold = 0;
            end
         end else begin
            m_hold++;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] eg;
      if (started) begin
         eg = '0;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         chk("model_grant", int'(grant), int'(eg));
         chk("model_sel", int'(sel), m_sel);
         chk("model_busy", int'(busy), int'(m_owner >= 0));
         chk("model_timeout", int'(timeout), int'(m_to));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [3:0] g,
                      input logic [1:0] s, input logic b,
                      input logic t);
      chk({nm, "_grant"}, int'(grant), int'(g));
      chk({nm, "_sel"}, int'(sel), int'(s));
      chk({nm, "_busy"}, int'(busy), int'(b));
      chk({nm, "_timeout"}, int'(timeout), int'(t));
   endtask

   task automatic pulse_done(input logic [3:0] d);
      done = d;
      tick();
      done = 4'b0000;
   endtask

   initial begin
      reset_n = 1'b0;
      req     = 4'b1111;
      done    = 4'b0000;
      tick();
      lit("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      lit("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);

      reset_n = 1'b1;
      req     = 4'b0100;
      tick();
      lit("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      pulse_done(4'b0100);
      lit("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
      req = 4'b1001;
      tick();
      lit("ptr_is_3", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      lit("drop_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req     = 4'b1111;
      tick();
      lit("rr0", 4'b0001, 2'd0, 1'b1, 1'b0);
      pulse_done(4'b0001);
      lit("rr1", 4'b0010, 2'd1, 1'b1, 1'b0);
      pulse_done(4'b0010);
      lit("rr2", 4'b0100, 2'd2, 1'b1, 1'b0);
      pulse_done(4'b0100);
      lit("rr3", 4'b1000, 2'd3, 1'b1, 1'b0);
      pulse_done(4'b1000);
      lit("rr0b", 4'b0001, 2'd0, 1'b1, 1'b0);
      pulse_done(4'b0001);
      lit("rr1b", 4'b0010, 2'd1, 1'b1, 1'b0);

      pulse_done(4'b1000);
      lit("ignored_done", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1000;
      tick();
      lit("drop_rel", 4'b1000, 2'd3, 1'b1, 1'b0);

      req = 4'b0100;
      tick();
      lit("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      reset_n = 1'b0;
      tick();
      lit("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      req     = 4'b0001;
      tick();
      lit("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

      req = 4'b0110;
      done = 4'b0001;
      tick();
      done = 4'b0000;
      lit("done_and_drop", 4'b0010, 2'd1, 1'b1, 1'b0);

      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req     = 4'b0011;
      tick();
      lit("hold_start", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
      repeat (3) tick();
      lit("hold_last", 4'b0001, 2'd0, 1'b1, 1'b0);
      tick();
      lit("revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
      tick();
      lit("after_revoke", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
      repeat (100) tick();
      lit("hold_forever", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif
      req = 4'b0000;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
